cprv_fetch_unit: RTL and testbench

CPRV_FETCH_UNIT -- requirements
Module: cprv_fetch_unit

---
 rtl/cprv_pkg.sv | 11 +
 rtl/cprv_sync_fifo.sv | 45 ++++
 rtl/cprv_fetch_unit.sv | 120 ++++++++++++
 tb/tb_cprv_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cprv_pkg.sv
// cprv_pkg: shared constants and the fetch-queue entry layout for the cprv fetch path
package cprv_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int FQ_PC_W = 64;
  localparam int FQ_INSTR_W = 32;
  // Fields are sized for the widest supported build; narrower builds zero-extend into them.
  typedef struct packed {
    logic [FQ_PC_W-1:0] pc;
    logic [FQ_INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/cprv_sync_fifo.sv
// cprv_sync_fifo: synchronous FIFO with flush; push and pop may coincide, even when full.
// Ports: clk, rst_n (sync, active-low), flush (clears contents), push/wdata, pop,
//        rdata (head entry, meaningful only while count != 0), count (occupancy).
module cprv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop) rptr <= inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/cprv_fetch_unit.sv
// cprv_fetch_unit: instruction fetch with credit-limited imem requests, in-order responses,
// redirect/flush with stale-response discard, and a small fetch queue towards ID.
// Ports: clk, rst_n (sync, active-low); redirect_valid_i/redirect_pc_i;
//        imem request valid_imem_o/ready_imem_i/instr_addr_imem_o;
//        imem response valid_if_i/ready_if_o/instr_data_imem_i;
//        ID side valid_id_o/ready_id_i/instr_data_id_o/instr_pc_id_o.
// Optional: CPRV_FETCH_PERF_EN adds perf_fetch_cnt_o and perf_stall_cnt_o.
module cprv_fetch_unit
  import cprv_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   valid_imem_o,
  input  logic                   ready_imem_i,
  output logic [ADDR_WIDTH-1:0]  instr_addr_imem_o,
  input  logic                   valid_if_i,
  output logic                   ready_if_o,
  input  logic [DATA_WIDTH-1:0]  instr_data_imem_i,
  output logic                   valid_id_o,
  input  logic                   ready_id_i,
  output logic [INSTR_WIDTH-1:0] instr_data_id_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_id_o
`ifdef CPRV_FETCH_PERF_EN
  ,
  output logic [63:0]            perf_fetch_cnt_o,
  output logic [63:0]            perf_stall_cnt_o
`endif
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int NL = DATA_WIDTH / INSTR_WIDTH;
  localparam int LW = NL > 1 ? $clog2(NL) : 1;

  logic [ADDR_WIDTH-1:0] pc_r, ifl_pc;
  logic [CW-1:0] outstanding, fq_count, discard_cnt;
  logic issue, resp, keep, pop;
  logic [INSTR_WIDTH-1:0] instr_sel;
  fq_entry_t fq_in, fq_out;

  // Credits: never request more than the fetch queue could absorb once everything returns,
  // so responses can always be accepted.
  assign ready_if_o = 1'b1;
  assign valid_imem_o = rst_n && !redirect_valid_i && outstanding < CW'(MAX_OUTSTANDING) &&
                        ({1'b0, outstanding} + {1'b0, fq_count}) < (CW + 1)'(FQ_DEPTH);
  assign instr_addr_imem_o = pc_r;
  assign issue = valid_imem_o && ready_imem_i;
  assign resp = rst_n && valid_if_i && outstanding != '0;
  assign keep = resp && discard_cnt == '0 && !redirect_valid_i;
  assign valid_id_o = rst_n && fq_count != '0;
  assign pop = valid_id_o && ready_id_i;
  assign instr_data_id_o = valid_id_o ? fq_out.instr[INSTR_WIDTH-1:0] : '0;
  assign instr_pc_id_o = valid_id_o ? fq_out.pc[ADDR_WIDTH-1:0] : '0;

  // Pick the instruction lane of the returned data word addressed by the request PC.
  generate
    if (NL > 1) begin : g_lane
      logic [LW-1:0] lane;
      assign lane = ifl_pc[LW+1:2];
      assign instr_sel = instr_data_imem_i[lane * INSTR_WIDTH +: INSTR_WIDTH];
    end else begin : g_single
      assign instr_sel = instr_data_imem_i[INSTR_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    fq_in = '0;
    fq_in.pc[ADDR_WIDTH-1:0] = ifl_pc;
    fq_in.instr[INSTR_WIDTH-1:0] = instr_sel;
  end

  cprv_sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FQ_DEPTH), .CW(CW)) u_fq (
    .clk(clk), .rst_n(rst_n), .flush(redirect_valid_i), .push(keep), .pop(pop),
    .wdata(fq_in), .rdata(fq_out), .count(fq_count)
  );

  // In-flight PCs; its occupancy is the outstanding-request count. Never flushed, because
  // discarded responses still have to retire their entry.
  cprv_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(MAX_OUTSTANDING), .CW(CW)) u_ifl (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .push(issue), .pop(resp),
    .wdata(pc_r), .rdata(ifl_pc), .count(outstanding)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
      discard_cnt <= '0;
    end else if (redirect_valid_i) begin
      pc_r <= redirect_pc_i & ~ADDR_WIDTH'(3);
      discard_cnt <= outstanding - CW'(resp);
    end else begin
      if (issue) pc_r <= pc_r + ADDR_WIDTH'(INSTR_BYTES);
      if (resp && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
    end
  end

`ifdef CPRV_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (pop) perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
      if (!valid_id_o) perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing in flight is a protocol error; the response is ignored.
  a_resp_credit: assert property (@(posedge clk) disable iff (!rst_n) valid_if_i |-> outstanding != '0);
`endif
endmodule

// File: tb/tb_cprv_fetch_unit.sv
// tb_cprv_fetch_unit: randomized self-checking bench with an in-order imem model and sequential-PC reference
module tb_cprv_fetch_unit;
  localparam int MAX_OUT = 2;
  localparam int FQ_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic valid_imem_o;
  logic ready_imem_i = 1'b0;
  logic [63:0] instr_addr_imem_o;
  logic valid_if_i = 1'b0;
  logic ready_if_o;
  logic [63:0] instr_data_imem_i = '0;
  logic valid_id_o;
  logic ready_id_i = 1'b0;
  logic [31:0] instr_data_id_o;
  logic [63:0] instr_pc_id_o;
`ifdef CPRV_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt_o, perf_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  cprv_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .valid_imem_o(valid_imem_o), .ready_imem_i(ready_imem_i), .instr_addr_imem_o(instr_addr_imem_o),
    .valid_if_i(valid_if_i), .ready_if_o(ready_if_o), .instr_data_imem_i(instr_data_imem_i),
    .valid_id_o(valid_id_o), .ready_id_i(ready_id_i),
    .instr_data_id_o(instr_data_id_o), .instr_pc_id_o(instr_pc_id_o)
`ifdef CPRV_FETCH_PERF_EN
    , .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  int errors = 0, checks = 0;
  int pr_ready = 100, pr_resp = 100, pr_id = 100;
  int n_pop, n_issue, stalls;
  bit const_data = 1'b0;
  bit last_vimem, last_vid, last_resp, last_pop;
  logic [63:0] exp_req, exp_id;
  logic [63:0] q_addr[$];

  // Memory image: 32-bit word stored at byte address a.
  function automatic logic [31:0] word(input logic [63:0] a);
    if (const_data) return a[2] ? 32'hAAAA_BBBB : 32'hCCCC_DDDD;
    return ((a[31:0] ^ 32'h5A5A_0000) * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  // Little-endian 64-bit line containing address a.
  function automatic logic [63:0] line(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    return {word(b + 64'd4), word(b)};
  endfunction

  task automatic set_rates(input int r, input int s, input int d);
    pr_ready = r;
    pr_resp = s;
    pr_id = d;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    ready_imem_i = 1'b0;
    valid_if_i = 1'b0;
    ready_id_i = 1'b0;
    repeat (n) begin
      #1;
      checks++;
      if (valid_imem_o !== 1'b0 || valid_id_o !== 1'b0 || instr_data_id_o !== '0 ||
          instr_pc_id_o !== '0 || ready_if_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_outputs: vimem=%b vid=%b instr=%h pc=%h ready_if=%b, required 0 0 0 0 1",
                 valid_imem_o, valid_id_o, instr_data_id_o, instr_pc_id_o, ready_if_o);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    q_addr.delete();
    exp_req = '0;
    exp_id = '0;
    n_pop = 0;
    n_issue = 0;
    #1;
    checks++;
    if (valid_imem_o !== 1'b1 || instr_addr_imem_o !== 64'h0) begin
      errors++;
      $display("FAIL first_request: valid=%b addr=%h, required 1 0000000000000000", valid_imem_o, instr_addr_imem_o);
    end
    stalls = 1;
  endtask

  task automatic step(input bit redir, input logic [63:0] rpc);
    @(negedge clk);
    redirect_valid_i = redir;
    redirect_pc_i = rpc;
    ready_imem_i = $urandom_range(99) < pr_ready;
    ready_id_i = $urandom_range(99) < pr_id;
    valid_if_i = q_addr.size() != 0 && $urandom_range(99) < pr_resp;
    if (valid_if_i) instr_data_imem_i = line(q_addr[0]);
    else instr_data_imem_i = {$urandom, $urandom};
    #1;
`ifdef CPRV_FETCH_PERF_EN
    checks++;
    if (perf_fetch_cnt_o !== 64'(n_pop) || perf_stall_cnt_o !== 64'(stalls)) begin
      errors++;
      $display("FAIL perf: fetch=%0d stall=%0d, required %0d %0d", perf_fetch_cnt_o, perf_stall_cnt_o, n_pop, stalls);
    end
`endif
    checks++;
    if (ready_if_o !== 1'b1 || (valid_imem_o && (redir || q_addr.size() >= MAX_OUT))) begin
      errors++;
      $display("FAIL imem_credit: valid_imem=%b ready_if=%b redirect=%b outstanding=%0d, required no request at limit/redirect and ready_if=1",
               valid_imem_o, ready_if_o, redir, q_addr.size());
    end
    if (valid_imem_o) begin
      checks++;
      if (instr_addr_imem_o !== exp_req) begin
        errors++;
        $display("FAIL request_addr: got %h, expected %h", instr_addr_imem_o, exp_req);
      end
    end
    if (!valid_id_o) begin
      checks++;
      stalls++;
      if (instr_data_id_o !== '0 || instr_pc_id_o !== '0) begin
        errors++;
        $display("FAIL id_idle: instr=%h pc=%h, required 0 0", instr_data_id_o, instr_pc_id_o);
      end
    end else if (ready_id_i) begin
      checks++;
      if (instr_pc_id_o !== exp_id || instr_data_id_o !== word(exp_id)) begin
        errors++;
        $display("FAIL id_stream: got pc=%h instr=%h, expected pc=%h instr=%h",
                 instr_pc_id_o, instr_data_id_o, exp_id, word(exp_id));
      end
      exp_id += 64'd4;
      n_pop++;
    end
    last_vimem = valid_imem_o;
    last_vid = valid_id_o;
    last_resp = valid_if_i;
    last_pop = valid_id_o && ready_id_i;
    if (valid_imem_o && ready_imem_i) begin
      q_addr.push_back(instr_addr_imem_o);
      exp_req += 64'd4;
      n_issue++;
    end
    if (valid_if_i) void'(q_addr.pop_front());
    if (redir) begin
      exp_req = rpc & ~64'd3;
      exp_id = exp_req;
    end
  endtask

  task automatic check_int(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic test_reset();
    set_rates(100, 100, 100);
    do_reset(3);
    step(1'b0, '0);
    check_int("reset_first_issue", n_issue, 1, 1);
  endtask

  task automatic test_sequential();
    set_rates(100, 100, 100);
    do_reset(2);
    repeat (20) step(1'b0, '0);
    check_int("seq_issues", n_issue, 20, 20);
    check_int("seq_pops", n_pop, 18, 18);
  endtask

  task automatic test_data_select();
    const_data = 1'b1;
    set_rates(100, 100, 100);
    do_reset(2);
    repeat (8) step(1'b0, '0);
    check_int("lane_pops", n_pop, 6, 6);
    const_data = 1'b0;
  endtask

  task automatic test_backpressure();
    set_rates(100, 100, 0);
    do_reset(2);
    repeat (10) step(1'b0, '0);
    check_int("bp_issues", n_issue, FQ_DEPTH, FQ_DEPTH);
    check_int("bp_vimem_low", int'(last_vimem), 0, 0);
    check_int("bp_vid_high", int'(last_vid), 1, 1);
    set_rates(100, 100, 100);
    repeat (20) step(1'b0, '0);
    check_int("bp_resume_pops", n_pop, 15, 20);
  endtask

  task automatic test_redirect();
    set_rates(100, 0, 100);
    do_reset(2);
    repeat (2) step(1'b0, '0);
    check_int("redir_outstanding", q_addr.size(), 2, 2);
    step(1'b1, 64'h103);
    set_rates(100, 100, 100);
    repeat (15) step(1'b0, '0);
    check_int("redir_pops", n_pop, 8, 15);
  endtask

  task automatic test_coincident();
    set_rates(100, 100, 100);
    do_reset(2);
    repeat (5) step(1'b0, '0);
    set_rates(100, 0, 0);
    step(1'b0, '0);
    check_int("coin_outstanding", q_addr.size(), 2, 2);
    set_rates(100, 100, 100);
    step(1'b1, 64'h200);
    check_int("coin_resp_and_pop", int'(last_resp && last_pop), 1, 1);
    step(1'b0, '0);
    check_int("coin_queue_empty", int'(last_vid), 0, 0);
    repeat (10) step(1'b0, '0);
    check_int("coin_pops", n_pop, 10, 20);
  endtask

  task automatic test_random();
    int p;
    logic [63:0] t;
    do_reset(2);
    for (int i = 0; i < 2500; i++) begin
      if (i % 50 == 0) set_rates($urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(30, 100));
      if (i == 1200) do_reset(2);
      p = $urandom_range(99);
      t = {$urandom, $urandom};
      if (p < 1) t = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31));
      step(p < 3, t);
    end
    set_rates(100, 100, 100);
    repeat (20) step(1'b0, '0);
    check_int("random_progress", n_pop, 1, 100000);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_data_select();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
